// File: rtl/pattern_gen_multi.sv
// pattern_gen_multi: multi-mode RGB565 test-pattern frame source; optional CRC-16 of each frame when PG_CRC_EN is defined
module pattern_gen_multi #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int COL_BITS   = 9,
    parameter int LINE_BITS  = 8,
    parameter int CHECK_LOG2 = 4,
    parameter int BOX_SIZE   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic                 frameReady,
    input  logic                 takingPixel,
    output logic                 validPixel,
    output logic                 newFrame,
    output logic [COL_BITS-1:0]  colAddr,
    output logic [LINE_BITS-1:0] lineAddr,
    output logic [15:0]          RGB,
    output logic [15:0]          crc,
    output logic                 crcValid
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [COL_BITS-1:0]  COL_LAST  = COL_BITS'(H_ACTIVE - 1);
    localparam logic [LINE_BITS-1:0] LINE_LAST = LINE_BITS'(V_ACTIVE - 1);
    localparam logic [COL_BITS-1:0]  BAR_LAST  = COL_BITS'(BAR_W - 1);
    localparam logic [COL_BITS-1:0]  BX_MAX    = COL_BITS'(H_ACTIVE - BOX_SIZE);
    localparam logic [LINE_BITS-1:0] BY_MAX    = LINE_BITS'(V_ACTIVE - BOX_SIZE);
    localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic {WAIT_READY, STREAM} state_t;

    state_t               state;
    logic [1:0]           mode_q;
    logic [15:0]          frame_cnt;
    logic [COL_BITS-1:0]  bx, bar_cnt;
    logic [LINE_BITS-1:0] by;
    logic                 dx, dy;
    logic [2:0]           bar_idx;

    logic                 load, xfer, col_end, frame_end, bar_adv, chk, in_box;
    logic [1:0]           n_mode;
    logic [COL_BITS-1:0]  n_col, n_bar_cnt, n_bx;
    logic [LINE_BITS-1:0] n_line, n_by;
    logic [2:0]           n_bar_idx;
    logic [15:0]          n_rgb;

    // Next raster position and its colour; the same path serves frame start and every transfer
    always_comb begin
        load      = state == WAIT_READY && frameReady;
        xfer      = state == STREAM && validPixel && takingPixel;
        col_end   = colAddr == COL_LAST;
        frame_end = xfer && col_end && lineAddr == LINE_LAST;
        bar_adv   = bar_cnt == BAR_LAST && bar_idx != 3'd7;
        n_mode    = load ? mode : mode_q;
        n_col     = load || col_end ? '0 : colAddr + 1'b1;
        n_line    = load ? '0 : col_end ? lineAddr + 1'b1 : lineAddr;
        n_bar_idx = load || col_end ? '0 : bar_adv ? bar_idx + 3'd1 : bar_idx;
        n_bar_cnt = load || col_end || bar_adv ? '0 : bar_cnt + 1'b1;
        chk       = 1'(n_col >> CHECK_LOG2) ^ 1'(n_line >> CHECK_LOG2);
        in_box    = n_col >= bx && 32'(n_col) < 32'(bx) + BOX_SIZE &&
                    n_line >= by && 32'(n_line) < 32'(by) + BOX_SIZE;
        n_rgb     = n_mode == 2'd0 ? BAR_RGB[n_bar_idx] :
                    n_mode == 2'd1 ? (chk ? 16'hFFFF : 16'h0000) :
                    n_mode == 2'd2 ? {5'(n_col >> (COL_BITS - 5)), 6'(n_line >> (LINE_BITS - 6)), frame_cnt[4:0]} :
                    in_box ? 16'hFFFF : 16'h001F;
        n_bx      = dx ? bx + 1'b1 : bx - 1'b1;
        n_by      = dy ? by + 1'b1 : by - 1'b1;
    end

    // Frame sequencer: start on frameReady, advance per transfer, animate at frame end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_READY;
            validPixel <= 1'b0;
            newFrame   <= 1'b0;
            colAddr    <= '0;
            lineAddr   <= '0;
            RGB        <= '0;
            mode_q     <= '0;
            frame_cnt  <= '0;
            bar_idx    <= '0;
            bar_cnt    <= '0;
            bx         <= '0;
            by         <= '0;
            dx         <= 1'b1;
            dy         <= 1'b1;
        end else if (load || (xfer && !frame_end)) begin
            state      <= STREAM;
            validPixel <= 1'b1;
            newFrame   <= load;
            mode_q     <= n_mode;
            colAddr    <= n_col;
            lineAddr   <= n_line;
            RGB        <= n_rgb;
            bar_idx    <= n_bar_idx;
            bar_cnt    <= n_bar_cnt;
        end else if (frame_end) begin
            state      <= WAIT_READY;
            validPixel <= 1'b0;
            newFrame   <= 1'b0;
            frame_cnt  <= frame_cnt + 16'd1;
            bx         <= n_bx;
            by         <= n_by;
            dx         <= n_bx == BX_MAX || n_bx == '0 ? ~dx : dx;
            dy         <= n_by == BY_MAX || n_by == '0 ? ~dy : dy;
        end
    end

`ifdef PG_CRC_EN
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    logic [15:0] crc_acc, crc_nxt;

    assign crc_nxt = crc_word(crc_acc, RGB);

    // Running CRC over transferred pixels, published as the last pixel is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_acc  <= 16'hFFFF;
            crc      <= '0;
            crcValid <= 1'b0;
        end else begin
            crcValid <= frame_end;
            if (load)
                crc_acc <= 16'hFFFF;
            else if (xfer)
                crc_acc <= crc_nxt;
            if (frame_end)
                crc <= crc_nxt;
        end
    end
`else
    assign crc      = '0;
    assign crcValid = 1'b0;
`endif
endmodule
